// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one DRAM read port among NUM_REQ pipeline stages.
// One transaction in flight at a time; the completion pulse goes back to the owner.
module mem_read_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_grant,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [NUM_REQ-1:0]        rsp_complete,
  output logic                      mem_req_valid,
  output logic [ADDR_W-1:0]         mem_req_addr,
  input  logic                      mem_req_ready,
  input  logic                      mem_rsp_valid,
  input  logic [DATA_W-1:0]         mem_rsp_data,
  output logic                      busy,
  output logic                      err_spurious
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   next_ptr;
  logic               any_req;
  logic [IDX_W:0]     cand_sum;
  logic [IDX_W-1:0]   cand;
  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
  logic [ADDR_W-1:0]  winner_addr;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr_unpack
    assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
  end

  // First valid requester found scanning upward from ptr, wrapping at NUM_REQ.
  always_comb begin
    winner   = '0;
    any_req  = 1'b0;
    cand_sum = '0;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand_sum >= (IDX_W+1)'(NUM_REQ)) begin
        cand_sum = cand_sum - (IDX_W+1)'(NUM_REQ);
      end
      cand = cand_sum[IDX_W-1:0];
      if (!any_req && req_valid[cand]) begin
        any_req = 1'b1;
        winner  = cand;
      end
    end
    winner_addr = addr_arr[winner];
    next_ptr    = (winner == IDX_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      ptr           <= '0;
      owner         <= '0;
      req_grant     <= '0;
      rsp_complete  <= '0;
      rsp_data      <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      busy          <= 1'b0;
      err_spurious  <= 1'b0;
    end else begin
      req_grant    <= '0;
      rsp_complete <= '0;
      // A response with no transaction waiting for it is dropped but remembered.
      if (mem_rsp_valid && state != WAIT_RSP) begin
        err_spurious <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (any_req) begin
            owner         <= winner;
            mem_req_addr  <= winner_addr;
            req_grant     <= NUM_REQ'(1) << winner;
            ptr           <= next_ptr;
            mem_req_valid <= 1'b1;
            busy          <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (mem_rsp_valid) begin
            rsp_data     <= mem_rsp_data;
            rsp_complete <= NUM_REQ'(1) << owner;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Self-checking bench for mem_read_arbiter: directed scenarios followed by random
// transactions, all compared against a transaction-level round-robin model.
module tb_mem_read_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  req_valid;
  logic [95:0] req_addr;
  logic [2:0]  req_grant;
  logic [63:0] rsp_data;
  logic [2:0]  rsp_complete;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic        busy;
  logic        err_spurious;

  int n_pass   = 0;
  int n_checks = 0;
  int model_ptr = 0;
  bit model_err = 1'b0;

  mem_read_arbiter #(.NUM_REQ(3), .ADDR_W(32), .DATA_W(64)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_addr(req_addr),
    .req_grant(req_grant),
    .rsp_data(rsp_data),
    .rsp_complete(rsp_complete),
    .mem_req_valid(mem_req_valid),
    .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data),
    .busy(busy),
    .err_spurious(err_spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Round-robin rule: first set bit scanning from p upward, modulo 3.
  function automatic int rr_pick(input int p, input logic [2:0] v);
    for (int k = 0; k < 3; k++) begin
      if (v[(p + k) % 3]) return (p + k) % 3;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_grant"}, 64'(req_grant), 64'd0);
    check_output({tag, "_complete"}, 64'(rsp_complete), 64'd0);
    check_output({tag, "_mem_valid"}, 64'(mem_req_valid), 64'd0);
    check_output({tag, "_busy"}, 64'(busy), 64'd0);
    check_output({tag, "_err"}, 64'(err_spurious), 64'd0);
    check_output({tag, "_rsp_data"}, rsp_data, 64'd0);
    check_output({tag, "_mem_addr"}, 64'(mem_req_addr), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    check_reset_outputs("reset");
    reset = 1'b0;
    model_ptr = 0;
    model_err = 1'b0;
  endtask

  // One complete transaction: request, optional back-pressure, optional response delay.
  task automatic apply_stimulus(input logic [2:0] v, input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] a2, input int rdly, input int sdly,
                                input logic [63:0] data, input bit keep_valid);
    logic [31:0] a [3];
    int w;
    a[0] = a0; a[1] = a1; a[2] = a2;
    req_valid = v;
    req_addr  = {a2, a1, a0};
    w = rr_pick(model_ptr, v);
    step();
    check_output("grant", 64'(req_grant), 64'(1) << w);
    check_output("mem_valid", 64'(mem_req_valid), 64'd1);
    check_output("mem_addr", 64'(mem_req_addr), 64'(a[w]));
    check_output("busy_issue", 64'(busy), 64'd1);
    model_ptr = (w + 1) % 3;
    if (!keep_valid) req_valid = 3'b000;
    for (int i = 0; i < rdly; i++) begin
      step();
      check_output("bp_mem_valid", 64'(mem_req_valid), 64'd1);
      check_output("bp_mem_addr", 64'(mem_req_addr), 64'(a[w]));
      check_output("bp_no_regrant", 64'(req_grant), 64'd0);
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    check_output("wait_mem_valid", 64'(mem_req_valid), 64'd0);
    check_output("wait_busy", 64'(busy), 64'd1);
    for (int i = 0; i < sdly; i++) begin
      step();
      check_output("wait_no_complete", 64'(rsp_complete), 64'd0);
    end
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = data;
    step();
    mem_rsp_valid = 1'b0;
    check_output("complete", 64'(rsp_complete), 64'(1) << w);
    check_output("rsp_data", rsp_data, data);
    check_output("busy_done", 64'(busy), 64'd0);
    check_output("err_state", 64'(err_spurious), 64'(model_err));
  endtask

  initial begin
    reset         = 1'b1;
    req_valid     = '0;
    req_addr      = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    step();
    do_reset();

    $display("[TB] single request from requester 1");
    apply_stimulus(3'b010, 32'h0, 32'h100, 32'h0, 0, 0, 64'hDEAD_BEEF_0000_0001, 1'b0);

    $display("[TB] all requesters continuously valid");
    do_reset();
    for (int t = 0; t < 6; t++) begin
      apply_stimulus(3'b111, 32'h1000, 32'h2000, 32'h3000, 0, 0, 64'(t) + 64'hA000, 1'b1);
    end
    req_valid = 3'b000;

    $display("[TB] back-pressure on mem_req_ready");
    step();
    apply_stimulus(3'b101, 32'h4444, 32'h5555, 32'h6666, 4, 2, 64'h0123_4567_89AB_CDEF, 1'b0);

    $display("[TB] spurious response in IDLE");
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'hBAD;
    step();
    mem_rsp_valid = 1'b0;
    model_err = 1'b1;
    check_output("spur_no_complete", 64'(rsp_complete), 64'd0);
    check_output("spur_busy", 64'(busy), 64'd0);
    check_output("spur_err", 64'(err_spurious), 64'd1);
    apply_stimulus(3'b001, 32'h7777, 32'h0, 32'h0, 1, 1, 64'h55AA, 1'b0);

    $display("[TB] reset during WAIT_RSP");
    req_valid = 3'b111;
    req_addr  = {32'h30, 32'h20, 32'h10};
    step();
    req_valid = 3'b000;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    do_reset();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'hFEED;
    step();
    mem_rsp_valid = 1'b0;
    model_err = 1'b1;
    check_output("late_no_complete", 64'(rsp_complete), 64'd0);
    check_output("late_err", 64'(err_spurious), 64'd1);
    apply_stimulus(3'b111, 32'hA0, 32'hA1, 32'hA2, 0, 0, 64'h1111, 1'b0);

    $display("[TB] randomized transactions");
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 3'b000;
        step();
        check_output("idle_no_grant", 64'(req_grant), 64'd0);
        check_output("idle_busy", 64'(busy), 64'd0);
      end
      apply_stimulus(3'($urandom_range(1, 7)), $urandom, $urandom, $urandom,
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end
    req_valid = 3'b000;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
